// File: rtl/seq_booth_divider_if.sv
// rtl/seq_booth_divider_if.sv - start/done handshake and result bundle for seq_booth_divider
interface seq_booth_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_booth_divider.sv
// rtl/seq_booth_divider.sv - sequential signed restoring divider, optional DIV_FAST_PATH_EN
module seq_booth_divider #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    seq_booth_divider_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvd_orig;
    logic             sign_q;
    logic             sign_r;
    logic             zero_l;
    logic             ovf_l;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   p_sh;
    logic [WIDTH+1:0] t;
    logic             in_zero;
    logic             in_ovf;
    logic             fast;

    // Operand magnitudes, trial subtraction and special-case detection
    always_comb begin
        abs_a   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        abs_b   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        p_sh    = {p[WIDTH-1:0], q[WIDTH-1]};
        t       = {1'b0, p_sh} - {2'b00, dvs};
        in_zero = (bus.divisor == '0);
        in_ovf  = (bus.dividend == MOST_NEG) && (bus.divisor == '1);
`ifdef DIV_FAST_PATH_EN
        // Q holds |dividend| and P is zero, so FIX's sign fix-up yields the
        // right answer for dividend 0 and divisor +/-1 without iterating.
        fast    = in_zero || (bus.dividend == '0) ||
                  (bus.divisor == WIDTH'(1)) || (bus.divisor == '1);
`else
        fast    = 1'b0;
`endif
    end

    // Control FSM, iteration datapath and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            p               <= '0;
            q               <= '0;
            dvs             <= '0;
            dvd_orig        <= '0;
            sign_q          <= 1'b0;
            sign_r          <= 1'b0;
            zero_l          <= 1'b0;
            ovf_l           <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        q        <= abs_a;
                        dvs      <= abs_b;
                        dvd_orig <= bus.dividend;
                        sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sign_r   <= bus.dividend[WIDTH-1];
                        zero_l   <= in_zero;
                        ovf_l    <= in_ovf;
                        p        <= '0;
                        bus.busy <= 1'b1;
                        if (fast) begin
                            count <= '0;
                            state <= FIX;
                        end else begin
                            count <= CW'(WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!t[WIDTH+1]) begin
                        p <= t[WIDTH:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        p <= p_sh;
                        q <= {q[WIDTH-2:0], 1'b0};
                    end
                    count <= count - 1'b1;
                    if (count == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    if (zero_l) begin
                        bus.quotient    <= '1;
                        bus.remainder   <= dvd_orig;
                        bus.div_by_zero <= 1'b1;
                        bus.overflow    <= 1'b0;
                    end else if (ovf_l) begin
                        bus.quotient    <= MOST_NEG;
                        bus.remainder   <= '0;
                        bus.div_by_zero <= 1'b0;
                        bus.overflow    <= 1'b1;
                    end else begin
                        bus.quotient    <= sign_q ? -q : q;
                        bus.remainder   <= sign_r ? -p[WIDTH-1:0] : p[WIDTH-1:0];
                        bus.div_by_zero <= 1'b0;
                        bus.overflow    <= 1'b0;
                    end
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_booth_divider.sv
// tb/tb_seq_booth_divider.sv - scoreboard bench for seq_booth_divider
module tb_seq_booth_divider;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         due;
    } exp_t;

    exp_t sb[$];

    seq_booth_divider_if #(.WIDTH(W)) bus();

    seq_booth_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for latency checks
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input logic [7:0] a, input logic [7:0] b);
`ifdef DIV_FAST_PATH_EN
        if (b == 8'h00 || a == 8'h00 || b == 8'h01 || b == 8'hFF)
            return 1;
`endif
        return W + 1;
    endfunction

    task automatic push_exp(input logic [7:0] a, b, q, r, input logic dz, ov);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz; e.ov = ov;
        e.due = cyc + lat(a, b);
        sb.push_back(e);
    endtask

    task automatic drive(input logic [7:0] a, b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
    endtask

    task automatic issue(input logic [7:0] a, b, q, r, input logic dz, ov);
        drive(a, b);
        push_exp(a, b, q, r, dz, ov);
    endtask

    task automatic model(input logic [7:0] a, b);
        int ai, bi;
        ai = $signed(a);
        bi = $signed(b);
        if (bi == 0)
            issue(a, b, 8'hFF, a, 1'b1, 1'b0);
        else if (ai == -128 && bi == -1)
            issue(a, b, 8'h80, 8'h00, 1'b0, 1'b1);
        else
            issue(a, b, 8'(ai / bi), 8'(ai % bi), 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pop and compare whenever done is presented
    initial begin
        exp_t       e;
        logic [7:0] pr;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: done=1 with no request outstanding, required 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("quotient %0h/%0h", e.a, e.b), 32'(bus.quotient), 32'(e.q));
                    check($sformatf("remainder %0h/%0h", e.a, e.b), 32'(bus.remainder), 32'(e.r));
                    check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
                    check("overflow", 32'(bus.overflow), 32'(e.ov));
                    check("latency", cyc, e.due);
                    if (!e.dz && !e.ov) begin
                        pr = bus.quotient * e.b + bus.remainder;
                        check("mult_property", 32'(pr), 32'(e.a));
                    end
                end
            end
        end
    end

    logic [7:0] vals [16] = '{8'd0, 8'd1, 8'hFF, 8'd2, 8'd7, 8'd100, 8'h9C, 8'd127,
                              8'h80, 8'h81, 8'd64, 8'hC0, 8'd13, 8'hF3, 8'd55, 8'hFD};

    // Directed stimulus followed by a model-checked operand sweep
    initial begin
        logic ok;
        logic seen;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_quotient", 32'(bus.quotient), 0);
        check("reset_remainder", 32'(bus.remainder), 0);
        check("reset_flags", {30'd0, bus.div_by_zero, bus.overflow}, 0);
        rst = 1'b0;

        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        ok = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            ok &= (bus.busy === 1'b1);
        end
        check("busy_window", 32'(ok), 1);
        @(negedge clk);
        check("busy_at_done", 32'(bus.busy), 0);
        drain();

        issue(8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0);
        drain();
        issue(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);
        drain();
        issue(8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0);
        drain();
        issue(8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 1'b0);
        drain();
        issue(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
        drain();

        issue(8'd50, 8'd3, 8'd16, 8'd2, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        drive(8'd90, 8'd9);
        drain();

        issue(8'd50, 8'd3, 8'd16, 8'd2, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen_for_b2b", 32'(seen), 1);
        bus.start    = 1'b1;
        bus.dividend = 8'd90;
        bus.divisor  = 8'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        push_exp(8'd90, 8'd9, 8'd10, 8'd0, 1'b0, 1'b0);
        drain();

        drive(8'd100, 8'd7);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus.busy), 0);
        check("async_rst_quotient", 32'(bus.quotient), 0);
        check("async_rst_remainder", 32'(bus.remainder), 0);
        check("async_rst_flags", {30'd0, bus.div_by_zero, bus.overflow}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        issue(8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                model(vals[i], vals[j]);
                drain();
            end
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
